byte_enable_reg_bank: RTL
=========================

# byte_enable_reg_bank

Parametrised bank of DEPTH registers, each DATA_W bits wide, with per-byte write enables, a ready/valid write port, a registered read port with write-first bypass, per-word dirty flags, and a soft-clear sweep engine. It is the multi-word, multi-lane successor to the team's single 16-bit byte-enabled flop. It sits between a bus-side register interface and datapath logic that needs byte-granular configuration storage.

## Interface
Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8, minimum 8.
- DEPTH, 4, number of words; must be a power of two, minimum 2.
- NB, DATA_W/8, derived byte-lane count; not overridable.
- ADDR_W, $clog2(DEPTH), derived address width; not overridable.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept; high only in IDLE.
- wr_addr  in  ADDR_W  write word index.
- wr_byteena  in  NB  per-byte write enable; bit i covers data[8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read word index.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  high one cycle after an accepted rd_en.
- clr_req  in  1  soft-clear request, single-cycle pulse.
- clr_busy  out  1  high while the clear sweep runs.
- dirty  out  DEPTH  bit k is set when word k has been written since the last reset or clear.

## Operation
- Reset (resetn low, asynchronous): all words 0, dirty 0, rd_data 0, rd_valid 0, clr_busy 0, state IDLE, sweep counter 0.
- Write commits on a clock edge when wr_valid && wr_ready.
  - Lanes with wr_byteena[i]=1 take wr_data. Other lanes hold their value.
  - dirty[wr_addr] is set only when wr_byteena is non-zero.
  - A write with all-zero wr_byteena completes the handshake but changes no storage and no dirty bit.
- Read: rd_en samples rd_addr. Next cycle rd_data = word and rd_valid = 1. With no read, rd_valid = 0 and rd_data holds its last value.
- Write-first bypass: if a committing write or sweep write targets rd_addr in the same cycle, rd_data returns the merged post-write word.
- FSM states:
  - IDLE: wr_ready=1, clr_busy=0. clr_req moves the FSM to CLEAR and loads the counter with 0.
  - CLEAR: wr_ready=0, clr_busy=1. Each cycle writes 0 to word[counter], clears dirty[counter], and increments the counter. Returns to IDLE after word DEPTH-1.
- clr_req while in CLEAR is ignored. A new request is not queued.
- clr_req and a valid write in the same IDLE cycle: the write commits, then the sweep erases it. The result is deterministic.
- Reads are always served during CLEAR. An already-swept word reads 0.
- Reset mid-sweep aborts immediately into the reset state.

## Timing
- Write latency: storage updates at the accepting edge and is visible to a read issued the same cycle, through the bypass.
- Read latency: exactly 1 cycle, with no bubbles; back-to-back reads are supported.
- Clear: clr_busy rises the cycle after clr_req and stays high for exactly DEPTH cycles. wr_ready rises on the cycle clr_busy falls.
- The counter wraps naturally at ADDR_W bits. The terminal condition is counter == DEPTH-1, with no overflow bit.
- No combinational path from any input to any output except to wr_ready, which depends only on state.

## Structure
- Package byte_enable_reg_bank_pkg holds:
  - the state enum (IDLE, CLEAR);
  - function nb(data_w) returning the lane count;
  - localparam BYTE_W = 8.
- Sub-module byte_lane_merge: purely combinational (old word, new data, byteena) -> merged word, parametrised by DATA_W. It is instantiated once for the write path and once for the read bypass.

## Test plan
- Reset then read all words: rd_data 0x0000 for each address, dirty = 4'b0000.
- Write addr 2, data 0xABCD, byteena 2'b01; then 0x1234 with 2'b10; read addr 2 -> 0x12CD; dirty = 4'b0100.
- Same-cycle write to addr 1 (0xBEEF, 2'b11) and read of addr 1 -> rd_data 0xBEEF next cycle, with rd_valid 1.
- Write 0x5555 with byteena 2'b00 to addr 3 -> handshake completes, word stays 0, dirty[3] stays 0.
- Fill all words, pulse clr_req:
  - clr_busy high for 4 cycles and wr_ready low throughout;
  - a read of addr 0 on the second sweep cycle -> 0;
  - after the sweep, all words 0 and dirty 0.
- Assert resetn low on the second sweep cycle -> outputs go to reset values immediately; after release the FSM is in IDLE with wr_ready 1.

Source files
------------

// File: rtl/byte_enable_reg_bank_pkg.sv
// Shared types and helpers for the byte-enabled register bank.
package byte_enable_reg_bank_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned nb(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: lanes with byteena set take new_data,
// the rest keep old_word.
module byte_lane_merge
  import byte_enable_reg_bank_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned NB     = nb(DATA_W)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [NB-1:0]     byteena,
  output logic [DATA_W-1:0] merged
);

  // Select each lane independently from old or new data.
  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (byteena[i]) begin
        merged[i*BYTE_W +: BYTE_W] = new_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/byte_enable_reg_bank.sv
// Bank of DEPTH byte-enabled registers with ready/valid write port,
// registered write-first read port, per-word dirty flags and a soft-clear sweep.
module byte_enable_reg_bank
  import byte_enable_reg_bank_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned NB     = nb(DATA_W),
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NB-1:0]     wr_byteena,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DEPTH-1:0]  dirty
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_fire;
  logic              rd_hit;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_merged;
  logic [DATA_W-1:0] rd_next;

  assign wr_fire = wr_valid && wr_ready;
  assign rd_hit  = wr_fire && (wr_addr == rd_addr);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: IDLE -> CLEAR on request, CLEAR -> IDLE after the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req)        state_d = CLEAR;
      CLEAR:   if (cnt_q == LAST)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    wr_ready = 1'b0;
    clr_busy = 1'b0;
    case (state_q)
      IDLE:    wr_ready = 1'b1;
      CLEAR:   clr_busy = 1'b1;
      default: wr_ready = 1'b0;
    endcase
  end

  // Sweep counter: loaded on request, walks every word while clearing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          cnt_q <= '0;
    else if (state_q == IDLE && clr_req)  cnt_q <= '0;
    else if (state_q == CLEAR)            cnt_q <= cnt_q + 1'b1;
  end

  byte_lane_merge #(.DATA_W(DATA_W)) u_wr_merge (
    .old_word (mem[wr_addr]),
    .new_data (wr_data),
    .byteena  (wr_byteena),
    .merged   (wr_merged)
  );

  byte_lane_merge #(.DATA_W(DATA_W)) u_rd_merge (
    .old_word (mem[rd_addr]),
    .new_data (wr_data),
    .byteena  (rd_hit ? wr_byteena : '0),
    .merged   (rd_merged)
  );

  // Bus writes and sweep writes never coincide: wr_ready is low in CLEAR.
  assign rd_next = (clr_busy && (cnt_q == rd_addr)) ? '0 : rd_merged;

  // Storage and dirty flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem   <= '{default: '0};
      dirty <= '0;
    end else begin
      if (wr_fire && (|wr_byteena)) begin
        mem[wr_addr]   <= wr_merged;
        dirty[wr_addr] <= 1'b1;
      end
      if (clr_busy) begin
        mem[cnt_q]   <= '0;
        dirty[cnt_q] <= 1'b0;
      end
    end
  end

  // Registered read port returning the post-write word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end

endmodule
